// File: rtl/cpu_pkg.sv
// Shared CPU encodings: stack/branch opcodes, register-bank SP ops, and stack controller FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
// Contents: op_e (PUSH/POP/CALL/RET), sp_op_e (NONE/INC/DEC), stk_state_e (IDLE/MEM/COMMIT),
//           op_is_push_like() helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SP_NONE = 2'b00,
        SP_INC  = 2'b01,
        SP_DEC  = 2'b10
    } sp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MEM    = 2'b01,
        ST_COMMIT = 2'b10
    } stk_state_e;

    // PUSH and CALL both write below SP and decrement it; POP and RET read at SP and increment it.
    function automatic logic op_is_push_like(input op_e o);
        return (o == OP_PUSH) || (o == OP_CALL);
    endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Full-descending stack controller for PUSH/POP/CALL/RET: one memory access, then SP/reg/PC commit.
// Latency: start at N, memReq from N+1, ack at M, done at M+1, idle at M+2 (3 cycles minimum);
//          overflow/underflow errs at N+1, a missing ack errs after ACK_TIMEOUT request cycles.
// Backpressure: memReq is held until memAck; start is ignored (not queued) whenever busy.
// Ports: clk/reset (sync, active-high); start/op/srcData/dstReg/spIn request; memReq/memWe/memAddr/
//        memWData/memAck/memRData memory side; regWrite/regWriteData/write/stackOp register bank;
//        pcLoad/pcOut return target; busy/done/err status.
module stack_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] STACK_BASE  = 32'h0000_1000,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0800,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srcData,
    input  logic [4:0]  dstReg,
    input  logic [31:0] spIn,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic        memAck,
    input  logic [31:0] memRData,
    output logic [4:0]  regWrite,
    output logic [31:0] regWriteData,
    output logic        write,
    output logic [1:0]  stackOp,
    output logic        pcLoad,
    output logic [31:0] pcOut,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
    // The last MEM cycle that may still see an ack: the counter is cleared on entry,
    // so this is the ACK_TIMEOUT-th request cycle.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);

    stk_state_e       r_state;
    stk_state_e       w_state_nxt;
    op_e              r_op;
    logic [31:0]      r_src;
    logic [31:0]      r_addr;
    logic [31:0]      r_rdata;
    logic [4:0]       r_dst;
    logic             r_we;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_err_set;
    logic             w_push_like;
    logic             w_bound_hit;

    // The bound check looks at the live inputs in the accept cycle; those are exactly the
    // values being latched, so this equals a check on the latched SP one cycle earlier.
    assign w_push_like = op_is_push_like(op_e'(op));
    assign w_bound_hit = w_push_like ? (spIn == STACK_LIMIT) : (spIn == STACK_BASE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_err_set   = 1'b0;
        memReq      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        write       = 1'b0;
        pcLoad      = 1'b0;
        stackOp     = SP_NONE;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (w_bound_hit) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_state_nxt = ST_MEM;
                    end
                end
            end
            ST_MEM: begin
                busy   = 1'b1;
                memReq = 1'b1;
                // An ack in the final allowed cycle beats the timeout.
                if (memAck) begin
                    w_state_nxt = ST_COMMIT;
                end else if (r_cnt == TMO_LAST) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                busy        = 1'b1;
                done        = 1'b1;
                stackOp     = op_is_push_like(r_op) ? SP_DEC : SP_INC;
                // r0 is hardwired; a POP into it still moves SP but writes nothing.
                write       = (r_op == OP_POP) && (r_dst != 5'd0);
                pcLoad      = (r_op == OP_RET);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= OP_PUSH;
            r_src   <= '0;
            r_addr  <= '0;
            r_rdata <= '0;
            r_dst   <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_err <= w_err_set;
            if (w_accept) begin
                r_op   <= op_e'(op);
                r_src  <= srcData;
                r_dst  <= dstReg;
                r_we   <= w_push_like;
                r_addr <= w_push_like ? (spIn - 32'd4) : spIn;
                r_cnt  <= '0;
            end
            if (r_state == ST_MEM) begin
                if (memAck) begin
                    r_rdata <= memRData;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign memWe        = r_we;
    assign memAddr      = r_addr;
    assign memWData     = r_src;
    assign regWrite     = r_dst;
    assign regWriteData = r_rdata;
    assign pcOut        = r_rdata;
    assign err          = r_err;

endmodule
